rv32_fetch_ctrl: RTL
====================

// Module: rv32_fetch_ctrl
// PURPOSE
//  Instruction-fetch sequencer between rv32_pc_v2 and the instruction memory port.
//  Issues one fetch per PC value over a req/gnt/rvalid handshake.
//  Throttles the PC through its busy input and buffers returned words in a small FIFO for decode.
//  Discards in-flight and buffered fetches when the PC signals flush (redirect or reset).
// PARAMETERS
//  IBUF_DEPTH  2  instruction buffer entries (power of 2, >=2)
//  BYTE_ADDR   0  0: imem_addr = pc (word address); 1: imem_addr = {pc[29:0],2'b00}
// PORTS
//  clk          in   1   clock
//  rst_n        in   1   async active-low reset
//  pc           in   32  current PC from rv32_pc_v2
//  pc_flush     in   1   flush from rv32_pc_v2; pc already holds the new target when high
//  pc_busy      out  1   to rv32_pc_v2 busy: 1 = hold PC this cycle
//  imem_req     out  1   fetch request
//  imem_addr    out  32  fetch address
//  imem_gnt     in   1   request accepted this cycle
//  imem_rvalid  in   1   response valid (exactly one per grant, in order, >=1 cycle after gnt)
//  imem_rdata   in   32  response instruction
//  if_valid     out  1   buffer head valid
//  if_instr     out  32  buffer head instruction
//  if_pc        out  32  PC of buffer head
//  id_ready     in   1   decode consumes head when if_valid & id_ready
// BEHAVIOUR
//  Reset: state=IDLE; buffer empty; if_valid=0, if_instr=0, if_pc=0; imem_req=0, imem_addr=0; pc_busy=1.
//  States:
//   IDLE:  waiting for buffer space.
//   REQ:   imem_req=1, imem_addr from pc.
//   WAIT:  one grant outstanding, awaiting rvalid.
//   DRAIN: outstanding response is stale and is dropped.
//  Space check: space = (count + outstanding) < IBUF_DEPTH; outstanding = (state==WAIT).
//  IDLE -> REQ when space; REQ is entered only with space.
//  REQ & imem_gnt:
//   - latch req_pc=pc; pc_busy=0 this cycle, so the PC advances; -> WAIT.
//   - pc_busy=1 in every other cycle and state.
//  WAIT & imem_rvalid:
//   - push {req_pc, imem_rdata}.
//   - -> REQ if space after push (accounting for a same-cycle pop), else IDLE.
//   - Back-to-back throughput: 1 instr per 2 cycles at 1-cycle memory latency.
//  pc_flush=1 (highest priority, any state):
//   - buffer cleared; a same-cycle push and pop are both discarded.
//   - IDLE/REQ -> REQ the next cycle at the new pc. A same-cycle gnt is treated as a grant at the new pc (req_pc=pc), -> WAIT.
//   - WAIT -> DRAIN. A rvalid arriving in the same cycle is dropped, -> REQ.
//  DRAIN & imem_rvalid: response dropped; -> REQ.
//  pc_flush during DRAIN: remain in DRAIN.
//  Simultaneous push and pop with buffer full: legal; count unchanged.
//  if_valid=0 while pc_flush=1 (combinational mask), so decode never sees a stale head.
//  FIFO pointers wrap modulo IBUF_DEPTH; count is $clog2(IBUF_DEPTH)+1 bits.
//  Async reset mid-transaction drops the outstanding response.
//  Memory must not return rvalid for a pre-reset grant.
//  Flush ownership: redirects reach rv32_pc_v2 only when pc_busy=0, so decode holds its branch request until accepted.
// STRUCTURE
//  Package rv32_fetch_pkg:
//   - typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} fetch_state_t.
//   - typedef struct packed {logic [31:0] pc; logic [31:0] instr;} ibuf_entry_t.
//  Sub-module rv32_ibuf:
//   - synchronous FIFO of ibuf_entry_t with push/pop/clear, full/empty/count.
//   - clear has priority over push/pop.
//  Top level: FSM, req_pc register, space logic, address formatting.
// TESTING
//  1) Reset, imem_gnt tied 1, rvalid 1 cycle after gnt, id_ready=1, pc from 0:
//     -> if_pc sequence 0,1,2,3; one fetch per 2 cycles; no duplicates or gaps.
//  2) id_ready=0, IBUF_DEPTH=2:
//     -> exactly 2 grants, then imem_req=0 and pc_busy=1.
//     -> raising id_ready resumes fetching at pc=2.
//  3) imem_gnt low for 5 cycles in REQ:
//     -> imem_req and imem_addr stable; pc_busy=1; pc unchanged.
//  4) pc_flush with pc=0x40 while WAIT for pc=5, rvalid 3 cycles later:
//     -> response dropped; next request addr=0x40; first if_pc=0x40.
//  5) pc_flush in the same cycle as rvalid and pop with a full buffer:
//     -> buffer empty next cycle; if_valid=0; next fetch at the new pc.
//  6) rst_n asserted mid-WAIT:
//     -> all outputs at reset values immediately (async); after release, fetch restarts at pc=0.
//  7) BYTE_ADDR=1, pc=3 -> imem_addr=0xC.

Source files
------------

// File: rtl/rv32_fetch_pkg.sv
// Shared types for the rv32 instruction-fetch slice: FSM states, buffer entries and
// the imem address formatting helper.
package rv32_fetch_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ibuf_entry_t;

  // Word-addressed PC mapped onto either a word or a byte address bus.
  function automatic logic [31:0] fmt_addr(input logic [31:0] pc, input logic byte_addr);
    return byte_addr ? {pc[29:0], 2'b00} : pc;
  endfunction

endpackage

// File: rtl/rv32_ibuf.sv
// Small synchronous FIFO holding fetched {pc, instr} pairs; clear beats push/pop.
module rv32_ibuf
  import rv32_fetch_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  ibuf_entry_t              data_i,
  input  logic                     pop_i,
  output ibuf_entry_t              data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned AW = $clog2(Depth);

  ibuf_entry_t   mem_q [Depth];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(Depth));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  // A push into a full buffer is accepted only when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/rv32_fetch_ctrl.sv
// Instruction-fetch sequencer: one imem request per PC value, PC throttling via busy,
// and an instruction buffer towards decode that is discarded on flush.
module rv32_fetch_ctrl
  import rv32_fetch_pkg::*;
#(
  parameter int unsigned IBUF_DEPTH = 2,
  parameter bit          BYTE_ADDR  = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] pc_i,
  input  logic        pc_flush_i,
  output logic        pc_busy_o,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  output logic [31:0] if_instr_o,
  output logic [31:0] if_pc_o,
  input  logic        id_ready_i
);

  localparam int unsigned CW = $clog2(IBUF_DEPTH) + 1;

  fetch_state_t  state_q, state_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic [CW-1:0] count;
  logic [CW:0]   occ, occ_after_push;
  logic          space, space_after_push;
  logic          push, pop, empty, full;
  ibuf_entry_t   head;

  // Occupancy counts the outstanding grant so the buffer can never overflow.
  assign occ              = {1'b0, count} + (CW+1)'(state_q == WAIT);
  assign space            = ~full & (occ < (CW+1)'(IBUF_DEPTH));
  assign occ_after_push   = {1'b0, count} + (CW+1)'(1) - (CW+1)'(pop);
  assign space_after_push = occ_after_push < (CW+1)'(IBUF_DEPTH);

  assign if_valid_o = ~empty & ~pc_flush_i;
  assign pop        = if_valid_o & id_ready_i;
  assign if_instr_o = head.instr;
  assign if_pc_o    = head.pc;

  always_comb begin
    state_d     = state_q;
    req_pc_d    = req_pc_q;
    push        = 1'b0;
    pc_busy_o   = 1'b1;
    imem_req_o  = 1'b0;
    imem_addr_o = '0;
    unique case (state_q)
      IDLE: begin
        if (pc_flush_i || space) state_d = REQ;
      end
      REQ: begin
        imem_req_o  = 1'b1;
        imem_addr_o = fmt_addr(pc_i, BYTE_ADDR);
        if (imem_gnt_i) begin
          req_pc_d  = pc_i;
          pc_busy_o = 1'b0;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (pc_flush_i) begin
          state_d = imem_rvalid_i ? REQ : DRAIN;
        end else if (imem_rvalid_i) begin
          push    = 1'b1;
          state_d = space_after_push ? REQ : IDLE;
        end
      end
      DRAIN: begin
        if (imem_rvalid_i) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
    end
  end

  rv32_ibuf #(
    .Depth (IBUF_DEPTH)
  ) u_ibuf (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (pc_flush_i),
    .push_i  (push),
    .data_i  ('{pc: req_pc_q, instr: imem_rdata_i}),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

endmodule
